// File: rtl/core_pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: owns the FD/DE/EM/MW
// valid bits and turns hazard, redirect and data-bus wait into stage enables.
module core_pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic             insert_nop,
    input  logic             ex_jump,
    input  logic             em_mem_req,
    input  logic             mem_ack,
    output logic             pc_hold,
    output logic             pc_redirect,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_valid,
    output logic             de_valid,
    output logic             em_valid,
    output logic             mw_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN, REFILL} state_t;

    localparam logic [2:0] REFILL_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_next;
    logic [2:0] refill_cnt, refill_cnt_next;
    logic       mem_wait, flush, hazard;

    assign mem_wait = em_valid & em_mem_req & ~mem_ack;
    assign flush    = de_valid & ex_jump;
    assign hazard   = insert_nop & fd_valid;

    always_comb begin
        pc_hold         = 1'b0;
        pc_redirect     = 1'b0;
        fd_en           = 1'b1;
        de_en           = 1'b1;
        em_en           = 1'b1;
        mw_en           = 1'b1;
        state_next      = state;
        refill_cnt_next = refill_cnt;
        if (mem_wait) begin
            pc_hold = 1'b1;
            fd_en   = 1'b0;
            de_en   = 1'b0;
            em_en   = 1'b0;
        end else if (flush) begin
            pc_redirect     = 1'b1;
            refill_cnt_next = REFILL_LOAD;
            // The redirect edge itself is the first squashed FD cycle.
            state_next      = (REFILL_LOAD == 3'd0) ? RUN : REFILL;
        end else begin
            if (hazard) begin
                pc_hold = 1'b1;
                fd_en   = 1'b0;
            end
            if (state == REFILL) begin
                refill_cnt_next = (refill_cnt == 3'd0) ? 3'd0 : 3'(refill_cnt - 3'd1);
                if (refill_cnt <= 3'd1) state_next = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            refill_cnt <= '0;
        end else begin
            state      <= state_next;
            refill_cnt <= refill_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fd_valid  <= 1'b0;
            de_valid  <= 1'b0;
            em_valid  <= 1'b0;
            mw_valid  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (mem_wait) begin
            mw_valid <= 1'b0;
        end else if (flush) begin
            fd_valid <= 1'b0;
            de_valid <= 1'b0;
            em_valid <= 1'b1;
            mw_valid <= em_valid;
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end else if (hazard) begin
            de_valid <= 1'b0;
            em_valid <= de_valid;
            mw_valid <= em_valid;
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end else begin
            fd_valid <= (state == REFILL) ? 1'b0 : if_valid;
            de_valid <= fd_valid;
            em_valid <= de_valid;
            mw_valid <= em_valid;
        end
    end

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Directed bench for core_pipe_ctrl: two instances (default and CNT_W=2,
// FLUSH_CYCLES=3) checked every cycle against a stage-list model.
module tb_core_pipe_ctrl;

    logic clk = 1'b0;
    logic rst_n, if_valid, insert_nop, ex_jump, em_mem_req, mem_ack;

    logic        hold  [2];
    logic        redir [2];
    logic [3:0]  en    [2];
    logic [3:0]  vld   [2];
    logic [31:0] sc    [2];
    logic [31:0] fc    [2];

    logic        h0, r0, fe0, de0, ee0, me0, fv0, dv0, ev0, mv0;
    logic        h1, r1, fe1, de1, ee1, me1, fv1, dv1, ev1, mv1;
    logic [31:0] sc0, fc0;
    logic [1:0]  sc1, fc1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // model: valids packed {fd,de,em,mw}, squash cycles remaining, counters
    logic [3:0]  m_v     [2];
    int unsigned m_rem   [2];
    int unsigned m_stall [2];
    int unsigned m_flush [2];
    int unsigned fc_par  [2] = '{2, 3};
    int unsigned cmax    [2] = '{32'hFFFF_FFFF, 3};

    always #5 clk = ~clk;

    core_pipe_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .insert_nop(insert_nop),
        .ex_jump(ex_jump), .em_mem_req(em_mem_req), .mem_ack(mem_ack),
        .pc_hold(h0), .pc_redirect(r0), .fd_en(fe0), .de_en(de0), .em_en(ee0), .mw_en(me0),
        .fd_valid(fv0), .de_valid(dv0), .em_valid(ev0), .mw_valid(mv0),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );

    core_pipe_ctrl #(.FLUSH_CYCLES(3), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .insert_nop(insert_nop),
        .ex_jump(ex_jump), .em_mem_req(em_mem_req), .mem_ack(mem_ack),
        .pc_hold(h1), .pc_redirect(r1), .fd_en(fe1), .de_en(de1), .em_en(ee1), .mw_en(me1),
        .fd_valid(fv1), .de_valid(dv1), .em_valid(ev1), .mw_valid(mv1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    assign hold[0]  = h0;
    assign hold[1]  = h1;
    assign redir[0] = r0;
    assign redir[1] = r1;
    assign en[0]    = {fe0, de0, ee0, me0};
    assign en[1]    = {fe1, de1, ee1, me1};
    assign vld[0]   = {fv0, dv0, ev0, mv0};
    assign vld[1]   = {fv1, dv1, ev1, mv1};
    assign sc[0]    = sc0;
    assign sc[1]    = {30'd0, sc1};
    assign fc[0]    = fc0;
    assign fc[1]    = {30'd0, fc1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 4'b0000;
            m_rem[i] = 0;
            m_stall[i] = 0;
            m_flush[i] = 0;
        end
    endtask

    // Check every output of both instances, then advance the model by one edge.
    task automatic compare_and_update();
        for (int i = 0; i < 2; i++) begin
            logic wait_m, fl_m, hz_m;
            logic ex_hold, ex_redir;
            logic [3:0] ex_en;
            wait_m = rst_n & m_v[i][1] & em_mem_req & ~mem_ack;
            fl_m   = rst_n & m_v[i][2] & ex_jump;
            hz_m   = rst_n & m_v[i][3] & insert_nop;
            ex_hold = 1'b0; ex_redir = 1'b0; ex_en = 4'b1111;
            if (wait_m) begin
                ex_hold = 1'b1; ex_en = 4'b0001;
            end else if (fl_m) begin
                ex_redir = 1'b1;
            end else if (hz_m) begin
                ex_hold = 1'b1; ex_en = 4'b0111;
            end
            chk($sformatf("pc_hold[%0d]", i), {31'd0, hold[i]}, {31'd0, ex_hold});
            chk($sformatf("pc_redirect[%0d]", i), {31'd0, redir[i]}, {31'd0, ex_redir});
            chk($sformatf("enables[%0d]", i), {28'd0, en[i]}, {28'd0, ex_en});
            chk($sformatf("valids[%0d]", i), {28'd0, vld[i]}, {28'd0, m_v[i]});
            chk($sformatf("stall_cnt[%0d]", i), sc[i], m_stall[i]);
            chk($sformatf("flush_cnt[%0d]", i), fc[i], m_flush[i]);
            if (rst_n) begin
                if (wait_m) begin
                    m_v[i][0] = 1'b0;
                end else if (fl_m) begin
                    m_v[i] = {3'b001, m_v[i][1]};
                    m_rem[i] = fc_par[i] - 1;
                    if (m_flush[i] < cmax[i]) m_flush[i]++;
                end else if (hz_m) begin
                    m_v[i] = {m_v[i][3], 1'b0, m_v[i][2], m_v[i][1]};
                    if (m_stall[i] < cmax[i]) m_stall[i]++;
                end else begin
                    m_v[i] = {(m_rem[i] > 0) ? 1'b0 : if_valid, m_v[i][3:1]};
                    if (m_rem[i] > 0) m_rem[i]--;
                end
            end
        end
        if (!rst_n) model_reset();
    endtask

    task automatic step(input logic r, input logic iv, input logic nop,
                        input logic jmp, input logic req, input logic ack);
        rst_n = r; if_valid = iv; insert_nop = nop; ex_jump = jmp;
        em_mem_req = req; mem_ack = ack;
        #3;
        compare_and_update();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_valids0"}, {28'd0, vld[0]}, 32'd0);
        chk({tag, "_valids1"}, {28'd0, vld[1]}, 32'd0);
        chk({tag, "_stall0"}, sc[0], 32'd0);
        model_reset();
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; if_valid = 1'b0; insert_nop = 1'b0; ex_jump = 1'b0;
        em_mem_req = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        // fill: fd/de/em after 3 edges, mw after 4
        repeat (3) step(1, 1, 0, 0, 0, 0);
        chk("fill3", {28'd0, vld[0]}, 32'b1110);
        step(1, 1, 0, 0, 0, 0);
        chk("fill4", {28'd0, vld[0]}, 32'b1111);

        // one hazard cycle
        step(1, 1, 1, 0, 0, 0);
        chk("hz_bubble", {28'd0, vld[0]}, 32'b1011);
        chk("hz_stall", sc[0], 32'd1);
        repeat (2) step(1, 1, 0, 0, 0, 0);

        // redirect with de_valid=1
        step(1, 1, 0, 1, 0, 0);
        chk("fl_squash", {28'd0, vld[0]}, 32'b0011);
        chk("fl_cnt", fc[0], 32'd1);
        step(1, 1, 0, 0, 0, 0);
        chk("refill_fd0_c2", {31'd0, vld[0][3]}, 32'd0);
        step(1, 1, 0, 0, 0, 0);
        chk("refill_fd0_c3", {31'd0, vld[0][3]}, 32'd1);
        chk("refill_fd1_c3", {31'd0, vld[1][3]}, 32'd0);
        repeat (4) step(1, 1, 0, 0, 0, 0);

        // mem wait masking pending jump and hazard
        repeat (3) begin
            step(1, 1, 1, 1, 1, 0);
            chk("mw_hold", {28'd0, vld[0]}, 32'b1110);
        end
        step(1, 1, 1, 1, 1, 1);
        chk("mw_ack_redirect", {28'd0, vld[0]}, 32'b0011);
        chk("mw_ack_flcnt", fc[0], 32'd2);

        // jump with de_valid=0 is a plain advance
        step(1, 1, 0, 1, 0, 0);
        chk("jump_noval", fc[0], 32'd2);

        // saturation: 5 more hazards (6 total)
        repeat (5) step(1, 1, 0, 0, 0, 0);
        repeat (5) step(1, 1, 1, 0, 0, 0);
        chk("stall_sat", sc[1], 32'd3);
        chk("stall_nosat", sc[0], 32'd6);

        // reset mid-REFILL
        repeat (2) step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        async_reset_check("rst_refill");
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("post_rst_fd0", {31'd0, vld[0][3]}, 32'd1);
        chk("post_rst_fd1", {31'd0, vld[1][3]}, 32'd1);

        // reset mid mem-wait
        repeat (4) step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        async_reset_check("rst_memwait");
        step(0, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
